alu_operand_a_mux: RTL and testbench
====================================

Name: alu_operand_a_mux

Overview:
- Selects the ALU first operand in the RISC-V datapath. Two sources feed it: the register-file read value (A) and the alternate source (B, e.g. PC).
- 1-bit select, 1-cycle registered output with valid/stall/flush control, so it slots into the execute-stage pipeline register.
- Sits between decode/operand fetch and the ALU.

Parameters:
- WIDTH, 32, data width of A, B and result.
- RESET_VALUE, 0, value loaded into the result register on reset and on flush.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  source 0 (register-file rs1 value).
- b  input  WIDTH  source 1 (alternate source, e.g. PC).
- operator  input  1  select: 0 -> a, 1 -> b.
- in_valid  input  1  inputs are valid this cycle.
- stall  input  1  hold current output; ignore new inputs.
- flush  input  1  discard pipeline contents.
- result_comb  output  WIDTH  combinational mux output (same cycle).
- result  output  WIDTH  registered mux output.
- out_valid  output  1  result holds a valid operand.
- sel_q  output  1  select value that produced the current result.

Behaviour:
- Combinational path: result_comb = operator ? b : a. Updates in the same cycle with zero latency, independent of clk/rst/stall/flush.
- Select width: only one bit is used. A wider value driven onto operator is truncated to bit 0 by port width, so a value of 5 selects b.
- Registered path, latency 1 cycle. Priority per rising edge: rst > flush > stall > load.
  - rst asserted (async, any time): result = RESET_VALUE, out_valid = 0, sel_q = 0 immediately. Takes effect mid-operation and overrides everything. Registers stay held while rst is high.
  - flush = 1: result = RESET_VALUE, out_valid = 0, sel_q = 0. flush wins over stall.
  - stall = 1 (no flush): result, out_valid and sel_q hold their previous values.
  - otherwise: result <= result_comb, sel_q <= operator, out_valid <= in_valid.
- in_valid = 0 with no stall: the data register still loads result_comb, but out_valid goes to 0. Consumers must ignore result when out_valid = 0.
- No internal state machine. The data path is pure select: no arithmetic, no sign/zero extension, full WIDTH passed unchanged.
- X on the operator input is not resolved. Any X propagates to the outputs.

Optional Feature:
- Macro: ALU_A_PARITY_EN.
- Defined:
  - Adds output result_parity (1 bit) = even parity (XOR-reduce) of the registered result.
  - Registered alongside result: same reset/flush value (parity of RESET_VALUE) and same stall hold.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Mux select: a=1, b=0, operator=1, in_valid=1 -> result_comb=0 immediately; next edge result=0, sel_q=1, out_valid=1.
- Mux select: a=1, b=0, operator=0 -> result_comb=1; next edge result=1, sel_q=0.
- Mux select: a=0, b=1, operator=0 -> result=0. Then drive operator with 5 (truncated to 1) -> result_comb=1, next edge result=1.
- Stall hold: load a=32'hDEADBEEF (operator=0), then stall=1 while a=32'h12345678 -> result stays 32'hDEADBEEF and result_comb=32'h12345678. Release stall -> next edge result=32'h12345678.
- Flush over stall: with out_valid=1, assert flush=1 and stall=1 together -> next edge result=0, out_valid=0, sel_q=0.
- Async reset: assert rst between clock edges with result=32'hFFFFFFFF -> result=0 and out_valid=0 without waiting for a clock edge. With ALU_A_PARITY_EN defined, a=32'h7 loaded -> result_parity=1.

Source files
------------

// File: rtl/alu_operand_a_mux_if.sv
// Bundles the ALU operand-A select inputs and its combinational/registered outputs.
// With ALU_A_PARITY_EN defined the bundle also carries result_parity.
interface alu_operand_a_mux_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             operator;
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] result_comb;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             sel_q;
`ifdef ALU_A_PARITY_EN
  logic             result_parity;

  modport master (
    output a, b, operator, in_valid, stall, flush,
    input  result_comb, result, out_valid, sel_q, result_parity
  );
  modport slave (
    input  a, b, operator, in_valid, stall, flush,
    output result_comb, result, out_valid, sel_q, result_parity
  );
`else
  modport master (
    output a, b, operator, in_valid, stall, flush,
    input  result_comb, result, out_valid, sel_q
  );
  modport slave (
    input  a, b, operator, in_valid, stall, flush,
    output result_comb, result, out_valid, sel_q
  );
`endif
endinterface

// File: rtl/alu_operand_a_mux.sv
// ALU operand-A mux: combinational select of a/b plus an execute-stage register.
// Optional ALU_A_PARITY_EN adds a registered even-parity bit of the result.
module alu_operand_a_mux #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  alu_operand_a_mux_if.slave bus
);

  // Handshake: there is no ready. in_valid qualifies the inputs of the cycle;
  // stall is the only backpressure and freezes the register; out_valid marks
  // result as usable and result must be ignored while out_valid is low.
  logic [WIDTH-1:0] result_comb;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic             sel_d;
  logic             sel_q;
  logic             out_valid_d;
  logic             out_valid_q;

  always_comb begin
    result_comb = bus.operator ? bus.b : bus.a;
    result_d    = result_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    // flush outranks stall; with neither, the data register loads even when in_valid is low
    if (bus.flush) begin
      result_d    = RESET_VALUE;
      sel_d       = 1'b0;
      out_valid_d = 1'b0;
    end else if (!bus.stall) begin
      result_d    = result_comb;
      sel_d       = bus.operator;
      out_valid_d = bus.in_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= RESET_VALUE;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.result_comb = result_comb;
  assign bus.result      = result_q;
  assign bus.sel_q       = sel_q;
  assign bus.out_valid   = out_valid_q;

`ifdef ALU_A_PARITY_EN
  logic parity_d;
  logic parity_q;

  // Derived from result_d so stall/flush/reset behaviour follows the data register exactly
  assign parity_d = ^result_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= ^RESET_VALUE;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign bus.result_parity = parity_q;
`endif

endmodule

// File: tb/tb_alu_operand_a_mux.sv
// Self-checking bench for alu_operand_a_mux: directed test-plan cases plus
// random stimulus checked through an expected-state queue.
module tb_alu_operand_a_mux;
  localparam int WIDTH = 32;
  localparam int EW    = WIDTH + 3;

  logic clk;
  logic rst;

  alu_operand_a_mux_if #(.WIDTH(WIDTH)) bus ();

  alu_operand_a_mux #(.WIDTH(WIDTH), .RESET_VALUE('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_compared = 0;
  int n_mismatch = 0;
  logic [EW-1:0] exp_q[$];

  // stimulus as issued, kept at integer level for the reference model
  logic [WIDTH-1:0] cur_a = '0;
  logic [WIDTH-1:0] cur_b = '0;
  int               cur_op = 0;
  bit               cur_iv = 0;
  bit               cur_st = 0;
  bit               cur_fl = 0;

  // reference model state: what the pipeline register should hold
  logic [WIDTH-1:0] m_result = '0;
  bit               m_sel = 0;
  bit               m_valid = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit parity_of(input logic [WIDTH-1:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  task automatic model_reset();
    m_result = '0;
    m_sel    = 0;
    m_valid  = 0;
  endtask

  // reference model: applies one clock edge worth of rules and queues the expectation
  always @(posedge clk) begin
    if (rst || cur_fl) begin
      model_reset();
    end else if (!cur_st) begin
      m_sel    = (cur_op % 2) == 1;
      m_result = m_sel ? cur_b : cur_a;
      m_valid  = cur_iv;
    end
    exp_q.push_back({parity_of(m_result), m_valid, m_sel, m_result});
  end

  // monitor: pops one expectation per edge and compares the registered outputs
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #2;
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatch++;
      $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("result",    64'(bus.result),    64'(e[WIDTH-1:0]));
      check("sel_q",     64'(bus.sel_q),     64'(e[WIDTH]));
      check("out_valid", 64'(bus.out_valid), 64'(e[WIDTH+1]));
`ifdef ALU_A_PARITY_EN
      check("result_parity", 64'(bus.result_parity), 64'(e[WIDTH+2]));
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int op,
                      input bit iv, input bit st, input bit fl);
    @(negedge clk);
    cur_a  = a;
    cur_b  = b;
    cur_op = op;
    cur_iv = iv;
    cur_st = st;
    cur_fl = fl;
    bus.a        = a;
    bus.b        = b;
    bus.operator = op[0];
    bus.in_valid = iv;
    bus.stall    = st;
    bus.flush    = fl;
    #1;
    check("result_comb", 64'(bus.result_comb), 64'(((op % 2) == 1) ? b : a));
  endtask

  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  initial begin
    rst          = 1'b1;
    bus.a        = '0;
    bus.b        = '0;
    bus.operator = 1'b0;
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_result",    64'(bus.result),    64'h0);
    check("reset_out_valid", 64'(bus.out_valid), 64'h0);
    check("reset_sel_q",     64'(bus.sel_q),     64'h0);
    rst = 1'b0;

    // mux select cases
    step(32'h1, 32'h0, 1, 1, 0, 0);
    check("sel_b_comb", 64'(bus.result_comb), 64'h0);
    after_edge();
    check("sel_b_sel_q", 64'(bus.sel_q), 64'h1);
    step(32'h1, 32'h0, 0, 1, 0, 0);
    after_edge();
    check("sel_a_result", 64'(bus.result), 64'h1);
    step(32'h0, 32'h1, 0, 1, 0, 0);
    step(32'h0, 32'h1, 5, 1, 0, 0);
    check("op5_comb", 64'(bus.result_comb), 64'h1);
    after_edge();
    check("op5_result", 64'(bus.result), 64'h1);

    // stall hold, then release
    step(32'hDEADBEEF, 32'h0, 0, 1, 0, 0);
    step(32'h12345678, 32'h0, 0, 1, 1, 0);
    after_edge();
    check("stall_hold", 64'(bus.result), 64'hDEADBEEF);
    step(32'h12345678, 32'h0, 0, 1, 0, 0);
    after_edge();
    check("stall_release", 64'(bus.result), 64'h12345678);

    // in_valid low still loads data but clears out_valid
    step(32'hA5A5A5A5, 32'h0, 0, 0, 0, 0);
    after_edge();
    check("invalid_load", 64'(bus.result), 64'hA5A5A5A5);
    check("invalid_ov",   64'(bus.out_valid), 64'h0);

    // flush over stall
    step(32'hCAFEF00D, 32'h0, 1, 1, 0, 0);
    step(32'hCAFEF00D, 32'hCAFEF00D, 1, 1, 1, 1);
    after_edge();
    check("flush_result", 64'(bus.result), 64'h0);
    check("flush_ov",     64'(bus.out_valid), 64'h0);

    // asynchronous reset mid-cycle
    step(32'hFFFFFFFF, 32'h0, 0, 1, 0, 0);
    step(32'hFFFFFFFF, 32'h0, 0, 1, 1, 0);
    after_edge();
    check("pre_rst_result", 64'(bus.result), 64'hFFFFFFFF);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_result", 64'(bus.result),    64'h0);
    check("async_rst_ov",     64'(bus.out_valid), 64'h0);
    check("async_rst_sel",    64'(bus.sel_q),     64'h0);
    @(negedge clk);
    rst = 1'b0;

    // parity of a small load
    step(32'h7, 32'h0, 0, 1, 0, 0);
    after_edge();
    check("load7_result", 64'(bus.result), 64'h7);
`ifdef ALU_A_PARITY_EN
    check("load7_parity", 64'(bus.result_parity), 64'h1);
`endif

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      step($urandom, $urandom, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end

    after_edge();
    after_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
